// File: rtl/mem_pkg.sv
// Shared definitions for the memory/writeback stage: access-size codes, FSM states
// and the byte-lane mask helper used by both the store path and load alignment.
package mem_pkg;

   // funct3[1:0] access size
   localparam logic [1:0] SizeByte   = 2'b00;
   localparam logic [1:0] SizeHalf   = 2'b01;
   localparam logic [1:0] SizeWord   = 2'b10;
   localparam logic [1:0] SizeDouble = 2'b11;

   // Full funct3 codes that need special handling
   localparam logic [2:0] F3Ld  = 3'b011;
   localparam logic [2:0] F3Lwu = 3'b110;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StHold
   } mem_state_e;

   // Byte-lane mask for an access of the given size, anchored at lane 0.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      unique case (sz)
         SizeByte:   m = 8'h01;
         SizeHalf:   m = 8'h03;
         SizeWord:   m = 8'h0F;
         SizeDouble: m = 8'hFF;
         default:    m = 8'h00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load formatter: shifts the addressed bytes of a memory word down to
// lane 0 and sign- or zero-extends them to the full datapath width.
module load_align
   import mem_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0]              rdata,
   input  logic [$clog2(XLEN/8)-1:0]    offset,
   input  logic [2:0]                   funct3,
   output logic [XLEN-1:0]              result
);

   localparam int unsigned STRB_W = XLEN / 8;

   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   bmask;
   logic [XLEN-1:0]   topbit;
   logic [STRB_W-1:0] lanes;
   logic              sign;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      lanes   = STRB_W'(size_mask(funct3[1:0]));
      bmask   = '0;
      for (int i = 0; i < int'(STRB_W); i++) begin
         bmask[8*i +: 8] = {8{lanes[i]}};
      end
      // Isolates the most significant bit covered by the access: the sign bit.
      topbit = bmask & ~(bmask >> 1);
      sign   = !funct3[2] && (|(shifted & topbit));
      result = (shifted & bmask) | (sign ? ~bmask : '0);
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access stage plus MEM/WB register: drives a req/ack data-memory port,
// detects misalignment, formats loads and holds writeback under back-pressure.
module mem_wb_stage
   import mem_pkg::*;
#(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        mem_read,
   input  logic                        mem_write,
   input  logic [2:0]                  funct3,
   input  logic [XLEN-1:0]             alu_result,
   input  logic [XLEN-1:0]             store_data,
   input  logic                        reg_write,
   input  logic [REG_ADDR_W-1:0]       rd_addr,
   input  logic                        flush,
   input  logic                        stall,
   output logic                        dmem_req,
   output logic                        dmem_we,
   output logic [XLEN-1:0]             dmem_addr,
   output logic [XLEN-1:0]             dmem_wdata,
   output logic [XLEN/8-1:0]           dmem_wstrb,
   input  logic                        dmem_ack,
   input  logic [XLEN-1:0]             dmem_rdata,
   output logic                        wb_valid,
   output logic [XLEN-1:0]             wb_result,
   output logic                        wb_reg_write,
   output logic [REG_ADDR_W-1:0]       wb_rd_addr,
   output logic                        misaligned,
   output logic [XLEN-1:0]             fault_addr
);

   localparam int unsigned STRB_W = XLEN / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);

   mem_state_e state_q, state_d;

   // Memory port registers
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [XLEN-1:0]       addr_q, addr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;

   // Latched operation
   logic                  is_load_q, is_load_d;
   logic [OFF_W-1:0]      off_q, off_d;
   logic [2:0]            f3_q, f3_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic                  rw_q, rw_d;
   logic                  kill_q, kill_d;

   // Result parked while writeback is stalled
   logic [XLEN-1:0]       pend_res_q, pend_res_d;
   logic                  pend_rw_q, pend_rw_d;
   logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;

   // Writeback registers
   logic                  wbv_q, wbv_d;
   logic [XLEN-1:0]       wbres_q, wbres_d;
   logic                  wbrw_q, wbrw_d;
   logic [REG_ADDR_W-1:0] wbrd_q, wbrd_d;
   logic                  mis_q, mis_d;
   logic [XLEN-1:0]       fa_q, fa_d;

   logic                  accept;
   logic                  is_mem;
   logic                  mis_in;
   logic                  rw_in;
   logic [OFF_W-1:0]      off_in;
   logic [OFF_W-1:0]      align_mask;
   logic [STRB_W-1:0]     strb_in;
   logic [XLEN-1:0]       ld_result;
   logic [XLEN-1:0]       res_fmt;

   load_align #(
      .XLEN(XLEN)
   ) u_load_align (
      .rdata (dmem_rdata),
      .offset(off_q),
      .funct3(f3_q),
      .result(ld_result)
   );

   always_comb begin
      in_ready   = (state_q == StIdle) && !stall;
      accept     = in_valid && in_ready && !flush;
      is_mem     = mem_read || mem_write;
      rw_in      = reg_write && (rd_addr != '0);
      off_in     = alu_result[OFF_W-1:0];
      align_mask = OFF_W'((4'd1 << funct3[1:0]) - 4'd1);
      strb_in    = STRB_W'(size_mask(funct3[1:0]));
      mis_in     = ((off_in & align_mask) != '0) ||
                   ((XLEN == 32) && ((funct3 == F3Ld) || (funct3 == F3Lwu) ||
                                     (funct3[1:0] == SizeDouble)));
      res_fmt    = is_load_q ? ld_result : '0;
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      is_load_d  = is_load_q;
      off_d      = off_q;
      f3_d       = f3_q;
      rd_d       = rd_q;
      rw_d       = rw_q;
      kill_d     = kill_q;
      pend_res_d = pend_res_q;
      pend_rw_d  = pend_rw_q;
      pend_rd_d  = pend_rd_q;
      wbv_d      = wbv_q;
      wbres_d    = wbres_q;
      wbrw_d     = wbrw_q;
      wbrd_d     = wbrd_q;
      mis_d      = mis_q;
      fa_d       = fa_q;

      // Without back-pressure the WB entry is a bubble unless something loads it below.
      if (!stall) begin
         wbv_d  = 1'b0;
         wbrw_d = 1'b0;
         mis_d  = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!is_mem) begin
                  wbv_d   = 1'b1;
                  wbres_d = alu_result;
                  wbrw_d  = rw_in;
                  wbrd_d  = rd_addr;
               end else if (mis_in) begin
                  wbv_d   = 1'b1;
                  wbres_d = '0;
                  wbrw_d  = 1'b0;
                  wbrd_d  = rd_addr;
                  mis_d   = 1'b1;
                  fa_d    = alu_result;
               end else begin
                  state_d   = StWait;
                  req_d     = 1'b1;
                  we_d      = mem_write;
                  addr_d    = {alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                  wdata_d   = store_data << {off_in, 3'b000};
                  wstrb_d   = strb_in << off_in;
                  is_load_d = !mem_write;
                  off_d     = off_in;
                  f3_d      = funct3;
                  rd_d      = rd_addr;
                  rw_d      = rw_in;
                  kill_d    = 1'b0;
               end
            end
         end
         StWait: begin
            // A flushed request still runs to completion; its result is dropped.
            if (flush) begin
               kill_d = 1'b1;
            end
            if (dmem_ack) begin
               req_d = 1'b0;
               we_d  = 1'b0;
               if (flush || kill_q) begin
                  state_d = StIdle;
               end else if (stall) begin
                  state_d    = StHold;
                  pend_res_d = res_fmt;
                  pend_rw_d  = is_load_q && rw_q;
                  pend_rd_d  = rd_q;
               end else begin
                  state_d = StIdle;
                  wbv_d   = 1'b1;
                  wbres_d = res_fmt;
                  wbrw_d  = is_load_q && rw_q;
                  wbrd_d  = rd_q;
               end
            end
         end
         StHold: begin
            if (flush) begin
               state_d = StIdle;
            end else if (!stall) begin
               state_d = StIdle;
               wbv_d   = 1'b1;
               wbres_d = pend_res_q;
               wbrw_d  = pend_rw_q;
               wbrd_d  = pend_rd_q;
            end
         end
         default: state_d = StIdle;
      endcase

      if (flush) begin
         wbv_d   = 1'b0;
         wbres_d = '0;
         wbrw_d  = 1'b0;
         wbrd_d  = '0;
         mis_d   = 1'b0;
         fa_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         is_load_q  <= 1'b0;
         off_q      <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
         rw_q       <= 1'b0;
         kill_q     <= 1'b0;
         pend_res_q <= '0;
         pend_rw_q  <= 1'b0;
         pend_rd_q  <= '0;
         wbv_q      <= 1'b0;
         wbres_q    <= '0;
         wbrw_q     <= 1'b0;
         wbrd_q     <= '0;
         mis_q      <= 1'b0;
         fa_q       <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         is_load_q  <= is_load_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         rd_q       <= rd_d;
         rw_q       <= rw_d;
         kill_q     <= kill_d;
         pend_res_q <= pend_res_d;
         pend_rw_q  <= pend_rw_d;
         pend_rd_q  <= pend_rd_d;
         wbv_q      <= wbv_d;
         wbres_q    <= wbres_d;
         wbrw_q     <= wbrw_d;
         wbrd_q     <= wbrd_d;
         mis_q      <= mis_d;
         fa_q       <= fa_d;
      end
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_wstrb   = wstrb_q;
   assign wb_valid     = wbv_q;
   assign wb_result    = wbres_q;
   assign wb_reg_write = wbrw_q;
   assign wb_rd_addr   = wbrd_q;
   assign misaligned   = mis_q;
   assign fault_addr   = fa_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (XLEN=64): a vector table of single transactions
// followed by hand-written stall, flush and reset sequences.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, mem_read, mem_write, reg_write, flush, stall;
   logic [2:0]  funct3;
   logic [63:0] alu_result, store_data;
   logic [4:0]  rd_addr;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [7:0]  dmem_wstrb;
   logic        wb_valid, wb_reg_write, misaligned;
   logic [63:0] wb_result, fault_addr;
   logic [4:0]  wb_rd_addr;

   int checks = 0;
   int errors = 0;

   mem_wb_stage #(
      .XLEN      (64),
      .REG_ADDR_W(5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .funct3      (funct3),
      .alu_result  (alu_result),
      .store_data  (store_data),
      .reg_write   (reg_write),
      .rd_addr     (rd_addr),
      .flush       (flush),
      .stall       (stall),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_wstrb  (dmem_wstrb),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .wb_valid    (wb_valid),
      .wb_result   (wb_result),
      .wb_reg_write(wb_reg_write),
      .wb_rd_addr  (wb_rd_addr),
      .misaligned  (misaligned),
      .fault_addr  (fault_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      string       name;
      logic        rd_op;
      logic        wr_op;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] sdata;
      logic        rw;
      logic [4:0]  rd;
      int          delay;
      logic [63:0] rdata;
      logic        exp_mis;
      logic [63:0] exp_addr;
      logic [7:0]  exp_strb;
      logic [63:0] exp_wdata;
      logic        chk_res;
      logic [63:0] exp_res;
      logic        exp_rw;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'b000;
      alu_result = '0;
      store_data = '0;
      reg_write  = 1'b0;
      rd_addr    = '0;
   endtask

   task automatic drive_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] sdata,
                           input logic rw, input logic [4:0] rd);
      in_valid   = 1'b1;
      mem_read   = rd_op;
      mem_write  = wr_op;
      funct3     = f3;
      alu_result = addr;
      store_data = sdata;
      reg_write  = rw;
      rd_addr    = rd;
   endtask

   // Applies one vector; returns at the negedge where its writeback is visible.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      chk({v.name, " in_ready"}, 64'(in_ready), 64'd1);
      drive_op(v.rd_op, v.wr_op, v.f3, v.addr, v.sdata, v.rw, v.rd);
      @(negedge clk);
      idle_inputs();
      if (!(v.rd_op || v.wr_op) || v.exp_mis) begin
         chk({v.name, " wb_valid"}, 64'(wb_valid), 64'd1);
         chk({v.name, " wb_reg_write"}, 64'(wb_reg_write), 64'(v.exp_rw));
         chk({v.name, " misaligned"}, 64'(misaligned), 64'(v.exp_mis));
         chk({v.name, " dmem_req"}, 64'(dmem_req), 64'd0);
         if (v.exp_mis) begin
            chk({v.name, " fault_addr"}, fault_addr, v.addr);
         end else begin
            chk({v.name, " wb_result"}, wb_result, v.exp_res);
            chk({v.name, " wb_rd_addr"}, 64'(wb_rd_addr), 64'(v.rd));
         end
      end else begin
         chk({v.name, " dmem_req"}, 64'(dmem_req), 64'd1);
         chk({v.name, " dmem_we"}, 64'(dmem_we), 64'(v.wr_op));
         chk({v.name, " dmem_addr"}, dmem_addr, v.exp_addr);
         chk({v.name, " dmem_wstrb"}, 64'(dmem_wstrb), 64'(v.exp_strb));
         chk({v.name, " dmem_wdata"}, dmem_wdata, v.exp_wdata);
         chk({v.name, " wait wb_valid"}, 64'(wb_valid), 64'd0);
         for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            chk({v.name, " held dmem_req"}, 64'(dmem_req), 64'd1);
            chk({v.name, " held dmem_addr"}, dmem_addr, v.exp_addr);
            chk({v.name, " held wb_valid"}, 64'(wb_valid), 64'd0);
         end
         dmem_ack   = 1'b1;
         dmem_rdata = v.rdata;
         @(negedge clk);
         dmem_ack   = 1'b0;
         dmem_rdata = '0;
         chk({v.name, " wb_valid"}, 64'(wb_valid), 64'd1);
         chk({v.name, " wb_reg_write"}, 64'(wb_reg_write), 64'(v.exp_rw));
         chk({v.name, " req dropped"}, 64'(dmem_req), 64'd0);
         chk({v.name, " misaligned"}, 64'(misaligned), 64'd0);
         if (v.chk_res) begin
            chk({v.name, " wb_result"}, wb_result, v.exp_res);
            chk({v.name, " wb_rd_addr"}, 64'(wb_rd_addr), 64'(v.rd));
         end
      end
   endtask

   initial begin
      //          name       rd wr f3      addr                   sdata                  rw rd  dly rdata                  mis exp_addr  strb   exp_wdata              chk res                     rw
      vecs[0]  = '{"alu",     0, 0, 3'b000, 64'h1234,              64'h0,                 1, 5,  0, 64'h0,                 0, 64'h0,    8'h00, 64'h0,                 1, 64'h1234,               1};
      vecs[1]  = '{"alu_rd0", 0, 0, 3'b000, 64'h99,                64'h0,                 1, 0,  0, 64'h0,                 0, 64'h0,    8'h00, 64'h0,                 1, 64'h99,                 0};
      vecs[2]  = '{"alu_norw",0, 0, 3'b000, 64'hDEAD_BEEF_0000_0001,64'h0,                0, 7,  0, 64'h0,                 0, 64'h0,    8'h00, 64'h0,                 1, 64'hDEAD_BEEF_0000_0001,0};
      vecs[3]  = '{"sb",      0, 1, 3'b000, 64'h1003,              64'hAB,                0, 2,  3, 64'h0,                 0, 64'h1000, 8'h08, 64'hAB00_0000,         0, 64'h0,                  0};
      vecs[4]  = '{"lb",      1, 0, 3'b000, 64'h2001,              64'h0,                 1, 10, 0, 64'h80FF,              0, 64'h2000, 8'h02, 64'h0,                 1, 64'hFFFF_FFFF_FFFF_FF80,1};
      vecs[5]  = '{"lbu",     1, 0, 3'b100, 64'h2001,              64'h0,                 1, 10, 0, 64'h80FF,              0, 64'h2000, 8'h02, 64'h0,                 1, 64'h80,                 1};
      vecs[6]  = '{"lw_mis",  1, 0, 3'b010, 64'h2002,              64'h0,                 1, 11, 0, 64'h0,                 1, 64'h0,    8'h00, 64'h0,                 0, 64'h0,                  0};
      vecs[7]  = '{"lh",      1, 0, 3'b001, 64'h3006,              64'h0,                 1, 12, 1, 64'h8001_0000_0000_0000,0, 64'h3000, 8'hC0, 64'h0,                 1, 64'hFFFF_FFFF_FFFF_8001,1};
      vecs[8]  = '{"lwu",     1, 0, 3'b110, 64'h3004,              64'h0,                 1, 13, 2, 64'hF000_0000_1234_5678,0, 64'h3000, 8'hF0, 64'h0,                 1, 64'h0000_0000_F000_0000,1};
      vecs[9]  = '{"lw",      1, 0, 3'b010, 64'h3004,              64'h0,                 1, 14, 0, 64'hF000_0000_1234_5678,0, 64'h3000, 8'hF0, 64'h0,                 1, 64'hFFFF_FFFF_F000_0000,1};
      vecs[10] = '{"sd",      0, 1, 3'b011, 64'h4000,              64'h1122_3344_5566_7788,1, 15, 1, 64'h0,                 0, 64'h4000, 8'hFF, 64'h1122_3344_5566_7788,0, 64'h0,                  0};
      vecs[11] = '{"sh_mis",  0, 1, 3'b001, 64'h4001,              64'h55,                0, 0,  0, 64'h0,                 1, 64'h0,    8'h00, 64'h0,                 0, 64'h0,                  0};
      vecs[12] = '{"sw",      0, 1, 3'b010, 64'h4004,              64'hCAFE_BABE,         0, 0,  0, 64'h0,                 0, 64'h4000, 8'hF0, 64'hCAFE_BABE_0000_0000,0, 64'h0,                  0};
      vecs[13] = '{"ld",      1, 0, 3'b011, 64'h4008,              64'h0,                 1, 16, 0, 64'h8877_6655_4433_2211,0, 64'h4008, 8'hFF, 64'h0,                 1, 64'h8877_6655_4433_2211,1};
      vecs[14] = '{"ld_mis",  1, 0, 3'b011, 64'h400C,              64'h0,                 1, 17, 0, 64'h0,                 1, 64'h0,    8'h00, 64'h0,                 0, 64'h0,                  0};
      vecs[15] = '{"sh",      0, 1, 3'b001, 64'h5002,              64'hBEEF,              0, 0,  2, 64'h0,                 0, 64'h5000, 8'h0C, 64'hBEEF_0000,         0, 64'h0,                  0};
      vecs[16] = '{"lhu_rd0", 1, 0, 3'b101, 64'h5002,              64'h0,                 1, 0,  0, 64'hABCD_0000,         0, 64'h5000, 8'h0C, 64'h0,                 1, 64'hABCD,               0};

      rst        = 1'b1;
      flush      = 1'b0;
      stall      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("reset dmem_req", 64'(dmem_req), 64'd0);
      chk("reset dmem_addr", dmem_addr, 64'd0);
      chk("reset dmem_wstrb", 64'(dmem_wstrb), 64'd0);
      chk("reset wb_valid", 64'(wb_valid), 64'd0);
      chk("reset wb_result", wb_result, 64'd0);
      chk("reset misaligned", 64'(misaligned), 64'd0);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Stall freezes a misaligned fault pulse.
      run_vec(vecs[6]);
      stall = 1'b1;
      @(negedge clk);
      chk("stall hold misaligned", 64'(misaligned), 64'd1);
      chk("stall hold wb_valid", 64'(wb_valid), 64'd1);
      chk("stall hold fault_addr", fault_addr, 64'h2002);
      chk("stall in_ready", 64'(in_ready), 64'd0);
      stall = 1'b0;
      @(negedge clk);
      chk("unstall misaligned", 64'(misaligned), 64'd0);
      chk("unstall wb_valid", 64'(wb_valid), 64'd0);

      // LD acked under stall parks in HOLD; a queued ALU op waits behind it.
      drive_op(1'b1, 1'b0, 3'b011, 64'h6000, 64'h0, 1'b1, 5'd3);
      @(negedge clk);
      idle_inputs();
      chk("hold pre dmem_req", 64'(dmem_req), 64'd1);
      dmem_ack   = 1'b1;
      dmem_rdata = 64'h0123_4567_89AB_CDEF;
      stall      = 1'b1;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      drive_op(1'b0, 1'b0, 3'b000, 64'h77, 64'h0, 1'b1, 5'd4);
      for (int i = 0; i < 4; i++) begin
         chk("hold dmem_req", 64'(dmem_req), 64'd0);
         chk("hold wb_valid", 64'(wb_valid), 64'd0);
         chk("hold in_ready", 64'(in_ready), 64'd0);
         if (i == 3) stall = 1'b0;
         @(negedge clk);
      end
      chk("hold release wb_valid", 64'(wb_valid), 64'd1);
      chk("hold release wb_result", wb_result, 64'h0123_4567_89AB_CDEF);
      chk("hold release wb_reg_write", 64'(wb_reg_write), 64'd1);
      chk("hold release wb_rd_addr", 64'(wb_rd_addr), 64'd3);
      chk("hold release in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      idle_inputs();
      chk("queued alu wb_result", wb_result, 64'h77);
      chk("queued alu wb_rd_addr", 64'(wb_rd_addr), 64'd4);

      // Flush in WAIT: request completes, result discarded.
      drive_op(1'b1, 1'b0, 3'b010, 64'h7000, 64'h0, 1'b1, 5'd6);
      @(negedge clk);
      idle_inputs();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush wait dmem_req", 64'(dmem_req), 64'd1);
      chk("flush wait wb_valid", 64'(wb_valid), 64'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = 64'h1111_2222;
      @(negedge clk);
      dmem_ack   = 1'b0;
      chk("flush ack dmem_req", 64'(dmem_req), 64'd0);
      chk("flush ack wb_valid", 64'(wb_valid), 64'd0);
      chk("flush ack wb_reg_write", 64'(wb_reg_write), 64'd0);
      chk("flush ack in_ready", 64'(in_ready), 64'd1);

      // Flush overrides stall and clears a valid WB entry.
      run_vec(vecs[0]);
      stall = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      stall = 1'b0;
      flush = 1'b0;
      chk("flush over stall wb_valid", 64'(wb_valid), 64'd0);
      chk("flush over stall wb_reg_write", 64'(wb_reg_write), 64'd0);

      // Flush in IDLE blocks accept.
      drive_op(1'b0, 1'b0, 3'b000, 64'h42, 64'h0, 1'b1, 5'd8);
      flush = 1'b1;
      @(negedge clk);
      idle_inputs();
      flush = 1'b0;
      chk("flush idle wb_valid", 64'(wb_valid), 64'd0);

      // Reset in WAIT drops the request asynchronously; a stray ack is then ignored.
      drive_op(1'b1, 1'b0, 3'b011, 64'h8000, 64'h0, 1'b1, 5'd9);
      @(negedge clk);
      idle_inputs();
      chk("rst wait pre dmem_req", 64'(dmem_req), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst async dmem_req", 64'(dmem_req), 64'd0);
      chk("rst async dmem_addr", dmem_addr, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post rst in_ready", 64'(in_ready), 64'd1);
      dmem_ack   = 1'b1;
      dmem_rdata = 64'hFFFF;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("idle ack wb_valid", 64'(wb_valid), 64'd0);
      chk("idle ack dmem_req", 64'(dmem_req), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
